// File: rtl/sparrow_pkg.sv
// Shared types and constants for the Sparrow write-back path.
package sparrow_pkg;

   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

endpackage

// File: rtl/sparrow_wb_ctrl_if.sv
// Bus bundle between the issue/execute stages and the write-back controller.
interface sparrow_wb_ctrl_if #(
   parameter int BUF_DEPTH = 2
);
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   logic             alu_valid_i;
   logic [4:0]       alu_rd_i;
   logic [31:0]      alu_data_i;
   logic             ll_issue_i;
   logic [4:0]       ll_issue_rd_i;
   logic             ll_valid_i;
   logic             ll_ready_o;
   logic [4:0]       ll_rd_i;
   logic [31:0]      ll_data_i;
   logic [4:0]       rs1_addr_i;
   logic [4:0]       rs2_addr_i;
   logic             rs1_busy_o;
   logic             rs2_busy_o;
   logic             rs1_fwd_o;
   logic             rs2_fwd_o;
   logic             rf_wr_en_o;
   logic [4:0]       rf_rd_addr_o;
   logic [31:0]      rf_wr_data_o;
   logic [CNT_W-1:0] ll_count_o;

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  ll_issue_i, ll_issue_rd_i,
      input  ll_valid_i, ll_rd_i, ll_data_i,
      input  rs1_addr_i, rs2_addr_i,
      output ll_ready_o, rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o,
      output rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o, ll_count_o
   );

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      output ll_issue_i, ll_issue_rd_i,
      output ll_valid_i, ll_rd_i, ll_data_i,
      output rs1_addr_i, rs2_addr_i,
      input  ll_ready_o, rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o,
      input  rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o, ll_count_o
   );

endinterface

// File: rtl/sparrow_fifo.sv
// Small synchronous FIFO of write-back requests; DEPTH must be a power of two.
module sparrow_fifo
   import sparrow_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  wb_req_t          push_data_i,
   input  logic             pop_i,
   output wb_req_t          head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   wb_req_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      count_d = count_q;
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so flop order never matters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // NOTE: storage is left unreset; count/pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/sparrow_wb_ctrl.sv
// Regfile write-port arbiter: ALU results win, buffered long-latency results drain
// otherwise; tracks pending long-latency destinations and flags bypass/stall per source.
module sparrow_wb_ctrl
   import sparrow_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   sparrow_wb_ctrl_if.slave         bus
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   wb_req_t             push_req, head;
   logic                fifo_full, fifo_empty;
   logic                push, pop;
   logic [CNT_W-1:0]    count;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                wr_req;
   logic [4:0]          wr_rd;
   logic [31:0]         wr_data;
   logic                wr_en;

   assign push_req = '{rd: bus.ll_rd_i, data: bus.ll_data_i};
   assign push     = bus.ll_valid_i & ~fifo_full;
   assign pop      = ~bus.alu_valid_i & ~fifo_empty;

   sparrow_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (push),
      .push_data_i (push_req),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (count)
   );

   always_comb begin
      wr_req  = 1'b0;
      wr_rd   = '0;
      wr_data = '0;
      if (bus.alu_valid_i) begin
         wr_req  = 1'b1;
         wr_rd   = bus.alu_rd_i;
         wr_data = bus.alu_data_i;
      end else if (!fifo_empty) begin
         wr_req  = 1'b1;
         wr_rd   = head.rd;
         wr_data = head.data;
      end
   end

   // x0 consumes the port cycle but never writes; reset masks any write immediately.
   assign wr_en = reset_n & wr_req & (wr_rd != 5'd0);

   always_comb begin
      busy_d = busy_q;
      if (pop && head.rd != 5'd0)
         busy_d[head.rd] = 1'b0;
      // Applied after the clear so a same-cycle re-issue keeps the register pending.
      if (bus.ll_issue_i && bus.ll_issue_rd_i != 5'd0)
         busy_d[bus.ll_issue_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy_q <= '0;
      else          busy_q <= busy_d;
   end

   assign bus.rf_wr_en_o   = wr_en;
   assign bus.rf_rd_addr_o = wr_rd;
   assign bus.rf_wr_data_o = wr_data;
   assign bus.rs1_fwd_o    = wr_en & (wr_rd == bus.rs1_addr_i);
   assign bus.rs2_fwd_o    = wr_en & (wr_rd == bus.rs2_addr_i);
   assign bus.rs1_busy_o   = busy_q[bus.rs1_addr_i] & ~bus.rs1_fwd_o;
   assign bus.rs2_busy_o   = busy_q[bus.rs2_addr_i] & ~bus.rs2_fwd_o;
   assign bus.ll_ready_o   = ~fifo_full;
   assign bus.ll_count_o   = count;

endmodule

// File: tb/tb_sparrow_wb_ctrl.sv
// Directed bench for sparrow_wb_ctrl: inputs change 1ns after the rising edge,
// combinational outputs are checked 1ns later, well before the next edge.
module tb_sparrow_wb_ctrl;

   logic clk;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] pend;

   sparrow_wb_ctrl_if #(.BUF_DEPTH(2)) bus ();

   sparrow_wb_ctrl #(.BUF_DEPTH(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_valid_i   = 1'b0;
      bus.alu_rd_i      = '0;
      bus.alu_data_i    = '0;
      bus.ll_issue_i    = 1'b0;
      bus.ll_issue_rd_i = '0;
      bus.ll_valid_i    = 1'b0;
      bus.ll_rd_i       = '0;
      bus.ll_data_i     = '0;
      bus.rs1_addr_i    = '0;
      bus.rs2_addr_i    = '0;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
      assert (rd == 5'd0 || !pend[rd]) else $error("ALU writes pending rd %0d", rd);
      bus.alu_valid_i = 1'b1;
      bus.alu_rd_i    = rd;
      bus.alu_data_i  = data;
   endtask

   task automatic drive_issue(input logic [4:0] rd);
      assert (rd == 5'd0 || !pend[rd]) else $error("issue to pending rd %0d", rd);
      if (rd != 5'd0) pend[rd] = 1'b1;
      bus.ll_issue_i    = 1'b1;
      bus.ll_issue_rd_i = rd;
   endtask

   task automatic drive_offer(input logic [4:0] rd, input logic [31:0] data);
      assert (rd == 5'd0 || pend[rd]) else $error("result for unissued rd %0d", rd);
      pend[rd] = 1'b0;
      bus.ll_valid_i = 1'b1;
      bus.ll_rd_i    = rd;
      bus.ll_data_i  = data;
   endtask

   initial begin
      pend    = '0;
      reset_n = 1'b0;
      idle();
      repeat (2) tick();

      // Reset state, including masking of an ALU write while reset is held
      check("rst_count", 32'(bus.ll_count_o), 32'd0);
      check("rst_ready", 32'(bus.ll_ready_o), 32'd1);
      drive_alu(5'd5, 32'hA5A5_A5A5);
      bus.rs1_addr_i = 5'd5;
      #1;
      check("rst_wr_en_masked", 32'(bus.rf_wr_en_o), 32'd0);
      check("rst_fwd_masked", 32'(bus.rs1_fwd_o), 32'd0);

      // 1: ALU write is visible the same cycle and forwarded
      reset_n = 1'b1;
      #1;
      check("t1_wr_en", 32'(bus.rf_wr_en_o), 32'd1);
      check("t1_addr", 32'(bus.rf_rd_addr_o), 32'd5);
      check("t1_data", bus.rf_wr_data_o, 32'hA5A5_A5A5);
      check("t1_rs1_fwd", 32'(bus.rs1_fwd_o), 32'd1);
      check("t1_rs1_busy", 32'(bus.rs1_busy_o), 32'd0);
      check("t1_rs2_fwd_x0", 32'(bus.rs2_fwd_o), 32'd0);
      tick();

      // 2: long-latency rd=7 stalls, then is bypassed on its write cycle
      idle();
      drive_issue(5'd7);
      bus.rs2_addr_i = 5'd7;
      #1;
      check("t2_busy_issue_cycle", 32'(bus.rs2_busy_o), 32'd0);
      tick();
      idle();
      bus.rs2_addr_i = 5'd7;
      #1;
      check("t2_busy_pending", 32'(bus.rs2_busy_o), 32'd1);
      check("t2_fwd_pending", 32'(bus.rs2_fwd_o), 32'd0);
      drive_offer(5'd7, 32'h0000_1234);
      #1;
      check("t2_ready", 32'(bus.ll_ready_o), 32'd1);
      check("t2_busy_offer", 32'(bus.rs2_busy_o), 32'd1);
      tick();
      idle();
      bus.rs2_addr_i = 5'd7;
      #1;
      check("t2_wr_en", 32'(bus.rf_wr_en_o), 32'd1);
      check("t2_addr", 32'(bus.rf_rd_addr_o), 32'd7);
      check("t2_data", bus.rf_wr_data_o, 32'h0000_1234);
      check("t2_fwd", 32'(bus.rs2_fwd_o), 32'd1);
      check("t2_busy_fwd", 32'(bus.rs2_busy_o), 32'd0);
      check("t2_count_1", 32'(bus.ll_count_o), 32'd1);
      tick();
      idle();
      bus.rs2_addr_i = 5'd7;
      #1;
      check("t2_busy_cleared", 32'(bus.rs2_busy_o), 32'd0);
      check("t2_wr_en_idle", 32'(bus.rf_wr_en_o), 32'd0);
      check("t2_count_0", 32'(bus.ll_count_o), 32'd0);

      // 3: ALU hogs the port for 4 cycles while three results arrive
      for (int r = 10; r <= 12; r++) begin
         idle();
         drive_issue(5'(r));
         tick();
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] exp_ready;
         logic [31:0] exp_count;
         exp_ready = (i < 2) ? 32'd1 : 32'd0;
         exp_count = (i < 2) ? 32'(i) : 32'd2;
         drive_alu(5'(i + 1), 32'hA0 + 32'(i));
         if (i < 3) drive_offer(5'(10 + i), 32'h100 + 32'(i));
         #1;
         check($sformatf("t3_ready_%0d", i), 32'(bus.ll_ready_o), exp_ready);
         check($sformatf("t3_count_%0d", i), 32'(bus.ll_count_o), exp_count);
         check($sformatf("t3_alu_addr_%0d", i), 32'(bus.rf_rd_addr_o), 32'(i + 1));
         tick();
      end
      bus.alu_valid_i = 1'b0;
      #1;
      check("t3_d0_ready", 32'(bus.ll_ready_o), 32'd0);
      check("t3_d0_addr", 32'(bus.rf_rd_addr_o), 32'd10);
      check("t3_d0_data", bus.rf_wr_data_o, 32'h100);
      tick();
      check("t3_d1_ready", 32'(bus.ll_ready_o), 32'd1);
      check("t3_d1_count", 32'(bus.ll_count_o), 32'd1);
      check("t3_d1_addr", 32'(bus.rf_rd_addr_o), 32'd11);
      check("t3_d1_data", bus.rf_wr_data_o, 32'h101);
      tick();
      bus.ll_valid_i = 1'b0;
      bus.rs1_addr_i = 5'd12;
      #1;
      check("t3_d2_count", 32'(bus.ll_count_o), 32'd1);
      check("t3_d2_addr", 32'(bus.rf_rd_addr_o), 32'd12);
      check("t3_d2_data", bus.rf_wr_data_o, 32'h102);
      check("t3_d2_fwd", 32'(bus.rs1_fwd_o), 32'd1);
      tick();
      check("t3_drained", 32'(bus.ll_count_o), 32'd0);
      check("t3_wr_en_idle", 32'(bus.rf_wr_en_o), 32'd0);

      // 4: x0 results consume the port but never write or touch the scoreboard
      idle();
      drive_issue(5'd20);
      tick();
      idle();
      drive_alu(5'd0, 32'h0000_BEEF);
      drive_offer(5'd0, 32'h0000_DEAD);
      bus.rs1_addr_i = 5'd20;
      #1;
      check("t4_alu_x0_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
      check("t4_rs1_busy", 32'(bus.rs1_busy_o), 32'd1);
      tick();
      idle();
      bus.rs1_addr_i = 5'd20;
      #1;
      check("t4_pop_x0_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
      check("t4_count_1", 32'(bus.ll_count_o), 32'd1);
      check("t4_rs2_x0_busy", 32'(bus.rs2_busy_o), 32'd0);
      tick();
      check("t4_count_0", 32'(bus.ll_count_o), 32'd0);
      check("t4_busy_kept", 32'(bus.rs1_busy_o), 32'd1);

      // 5: re-issue of rd=9 on the cycle its result is written keeps it busy
      idle();
      drive_issue(5'd9);
      tick();
      idle();
      drive_offer(5'd9, 32'h0000_0099);
      tick();
      idle();
      drive_issue(5'd9);
      bus.rs1_addr_i = 5'd9;
      #1;
      check("t5_wr_en", 32'(bus.rf_wr_en_o), 32'd1);
      check("t5_addr", 32'(bus.rf_rd_addr_o), 32'd9);
      check("t5_fwd", 32'(bus.rs1_fwd_o), 32'd1);
      tick();
      idle();
      bus.rs1_addr_i = 5'd9;
      #1;
      check("t5_set_wins", 32'(bus.rs1_busy_o), 32'd1);
      check("t5_fwd_after", 32'(bus.rs1_fwd_o), 32'd0);

      // 6: reset mid-operation drops buffered results and pending bits
      idle();
      drive_alu(5'd1, 32'h0000_0001);
      drive_issue(5'd3);
      drive_offer(5'd20, 32'h0000_2020);
      tick();
      bus.ll_issue_i = 1'b0;
      drive_offer(5'd9, 32'h0000_0909);
      tick();
      bus.ll_valid_i = 1'b0;
      bus.rs1_addr_i = 5'd3;
      bus.rs2_addr_i = 5'd20;
      #1;
      check("t6_count_2", 32'(bus.ll_count_o), 32'd2);
      check("t6_ready_full", 32'(bus.ll_ready_o), 32'd0);
      check("t6_busy3", 32'(bus.rs1_busy_o), 32'd1);
      reset_n = 1'b0;
      pend    = '0;
      #1;
      check("t6_rst_count", 32'(bus.ll_count_o), 32'd0);
      check("t6_rst_ready", 32'(bus.ll_ready_o), 32'd1);
      check("t6_rst_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
      check("t6_rst_busy3", 32'(bus.rs1_busy_o), 32'd0);
      check("t6_rst_busy20", 32'(bus.rs2_busy_o), 32'd0);
      idle();
      tick();
      reset_n = 1'b1;
      bus.rs1_addr_i = 5'd9;
      #1;
      check("t6_rel_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
      check("t6_rel_count", 32'(bus.ll_count_o), 32'd0);
      check("t6_rel_busy9", 32'(bus.rs1_busy_o), 32'd0);
      tick();
      check("t6_no_stale_write", 32'(bus.rf_wr_en_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
